fp32_16_pipe: RTL and testbench

//  Pipelined binary32 -> binary16 converter. Narrowing companion to the fp16->fp32 widener.

---
 rtl/fp32_16_pipe_pkg.sv | 44 ++++
 rtl/fp32_16_pipe_rne_round.sv | 30 +++
 rtl/fp32_16_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp32_16_pipe.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp32_16_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared binary32/binary16 constants and stage-1 record types.
// Revision: 1.0
// ============================================================================
package fp_pkg;

    localparam int FP32_BIAS  = 127;
    localparam int FP16_BIAS  = 15;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [14:0] FP16_INF  = 15'h7C00;
    localparam logic [14:0] FP16_QNAN = 15'h7E00;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_SUB  = 3'd2,
        CLS_OVF  = 3'd3,
        CLS_INF  = 3'd4,
        CLS_NAN  = 3'd5
    } cls_t;

    // sig keeps the raw fraction in [22:0] for every class so NaN payload
    // and zero/denormal detection can be done late.
    typedef struct packed {
        logic        sign;
        cls_t        cls;
        logic [23:0] sig;
        logic [4:0]  exp;
        logic [4:0]  shift;
    } s1_t;

endpackage
`default_nettype wire

// File: rtl/fp32_16_pipe_rne_round.sv
`default_nettype none
// ============================================================================
// Module  : fp_rne_round
// Brief   : Combinational round-to-nearest-even on a packed {exp, mantissa}.
// Revision: 1.0
// ============================================================================
module fp_rne_round (
    input  logic [4:0] i_exp,
    input  logic [9:0] i_man,
    input  logic       i_g,
    input  logic       i_s,
    output logic [4:0] o_exp,
    output logic [9:0] o_man,
    output logic       o_carry,
    output logic       o_inexact
);

    logic        w_up;
    logic [15:0] w_sum;

    // Mantissa carry ripples into the exponent, giving subnormal->min-normal for free.
    assign w_up      = i_g & (i_s | i_man[0]);
    assign w_sum     = {1'b0, i_exp, i_man} + {15'd0, w_up};
    assign o_exp     = w_sum[14:10];
    assign o_man     = w_sum[9:0];
    assign o_carry   = w_sum[15];
    assign o_inexact = i_g | i_s;

endmodule
`default_nettype wire

// File: rtl/fp32_16_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp32_16_pipe
// Brief   : Two-stage valid/ready binary32 -> binary16 converter, RNE, flags.
// Revision: 1.0
// ============================================================================
module fp32_16_pipe
    import fp_pkg::*;
#(
    parameter bit FLUSH_SUB = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_flags
);

    logic        r_v1;
    logic        r_v2;
    s1_t         r_s1;
    logic [15:0] r_data;
    logic [3:0]  r_flags;

    logic        w_adv1;
    logic        w_adv2;
    logic [7:0]  w_e;
    s1_t         w_s1;

    assign w_adv2    = !r_v2 | out_ready;
    assign w_adv1    = !r_v1 | w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v2;
    assign out_data  = r_data;
    assign out_flags = r_flags;

    assign w_e = in_data[30:23];

    // Exponent arithmetic is done mod 32: e-112 == e[4:0]+16 and 126-e == 30-e[4:0]
    // over the ranges where each result is actually used.
    always_comb begin
        w_s1       = '0;
        w_s1.sign  = in_data[31];
        w_s1.sig   = {(w_e != 8'd0), in_data[22:0]};
        w_s1.exp   = w_e[4:0] + 5'd16;
        w_s1.shift = (w_e <= 8'd100) ? 5'd26 : (5'd30 - w_e[4:0]);
        if (w_e == 8'hFF)
            w_s1.cls = (in_data[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (w_e == 8'd0)
            w_s1.cls = CLS_ZERO;
        else if (w_e > 8'd142)
            w_s1.cls = CLS_OVF;
        else if (w_e >= 8'd113)
            w_s1.cls = CLS_NORM;
        else
            w_s1.cls = CLS_SUB;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid)
                r_s1 <= w_s1;
        end
    end

    logic [4:0]  w_k;
    logic [35:0] w_sub;
    logic [4:0]  w_rin_exp;
    logic [9:0]  w_rin_man;
    logic        w_rin_g;
    logic        w_rin_s;
    logic [4:0]  w_rexp;
    logic [9:0]  w_rman;
    logic        w_rcarry;
    logic        w_rnx;
    logic [15:0] w_data;
    logic [3:0]  w_flags;

    // Shift is at least 14 on the subnormal path, so pre-align by 14 to keep the vector narrow.
    assign w_k   = r_s1.shift - 5'd14;
    assign w_sub = {r_s1.sig, 12'd0} >> w_k;

    always_comb begin
        w_rin_exp = r_s1.exp;
        w_rin_man = r_s1.sig[22:13];
        w_rin_g   = r_s1.sig[12];
        w_rin_s   = |r_s1.sig[11:0];
        if (r_s1.cls == CLS_SUB) begin
            w_rin_exp = 5'd0;
            w_rin_man = w_sub[35:26];
            w_rin_g   = w_sub[25];
            w_rin_s   = |w_sub[24:0];
        end
    end

    fp_rne_round u_round (
        .i_exp     (w_rin_exp),
        .i_man     (w_rin_man),
        .i_g       (w_rin_g),
        .i_s       (w_rin_s),
        .o_exp     (w_rexp),
        .o_man     (w_rman),
        .o_carry   (w_rcarry),
        .o_inexact (w_rnx)
    );

    always_comb begin
        w_data  = {r_s1.sign, 15'd0};
        w_flags = 4'd0;
        case (r_s1.cls)
            CLS_NAN: begin
                w_data          = {r_s1.sign, 5'h1F, 1'b1, r_s1.sig[21:13]};
                w_flags[FLG_NV] = !r_s1.sig[22];
            end
            CLS_INF: w_data = {r_s1.sign, FP16_INF};
            CLS_ZERO: begin
                w_flags[FLG_UF] = |r_s1.sig[22:0];
                w_flags[FLG_NX] = |r_s1.sig[22:0];
            end
            CLS_OVF: begin
                w_data          = {r_s1.sign, FP16_INF};
                w_flags[FLG_OF] = 1'b1;
                w_flags[FLG_NX] = 1'b1;
            end
            CLS_NORM: begin
                if (w_rcarry || (w_rexp == 5'h1F)) begin
                    w_data          = {r_s1.sign, FP16_INF};
                    w_flags[FLG_OF] = 1'b1;
                    w_flags[FLG_NX] = 1'b1;
                end else begin
                    w_data          = {r_s1.sign, w_rexp, w_rman};
                    w_flags[FLG_NX] = w_rnx;
                end
            end
            CLS_SUB: begin
                if (FLUSH_SUB && (w_rexp == 5'd0)) begin
                    w_flags[FLG_UF] = 1'b1;
                    w_flags[FLG_NX] = 1'b1;
                end else begin
                    w_data          = {r_s1.sign, w_rexp, w_rman};
                    w_flags[FLG_UF] = w_rnx;
                    w_flags[FLG_NX] = w_rnx;
                end
            end
            default: begin
                w_data  = {r_s1.sign, 15'd0};
                w_flags = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2    <= 1'b0;
            r_data  <= 16'h0000;
            r_flags <= 4'h0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data  <= w_data;
                r_flags <= w_flags;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_16_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp32_16_pipe
// Brief   : Directed self-checking bench for fp32_16_pipe.
// Revision: 1.0
// ============================================================================
module tb_fp32_16_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp32_16_pipe #(.FLUSH_SUB(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    localparam int NV = 13;
    logic [31:0] d_in  [0:NV-1] = '{
        32'h3F800000, 32'h477FE000, 32'h477FF000, 32'h3F801000,
        32'h3F803000, 32'h33800000, 32'h33000000, 32'h80000001,
        32'h7FC00001, 32'h7F800001, 32'hFF800000, 32'h387FE000,
        32'h38800000};
    // {flags, data}
    logic [19:0] d_exp [0:NV-1] = '{
        20'h0_3C00, 20'h0_7BFF, 20'h5_7C00, 20'h1_3C00,
        20'h1_3C02, 20'h0_0001, 20'h3_0000, 20'h3_8000,
        20'h0_7E00, 20'h8_7E00, 20'h0_FC00, 20'h3_0400,
        20'h0_0400};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          idx_in;
    int          idx_out;
    logic        prev_stall;
    logic [19:0] prev_obs;
    logic        fire_in;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_flags", out_flags, 4'h0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors, one at a time, with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_data  = d_in[i];
            tick();
            in_valid = 1'b0;
            chk($sformatf("lat1_valid_%0d", i), out_valid, 0);
            tick();
            chk($sformatf("lat2_valid_%0d", i), out_valid, 1);
            chk($sformatf("vec_%0d_%h", i, d_in[i]), {out_flags, out_data}, d_exp[i]);
        end
        tick();

        // Back-to-back stream with a 3-cycle output stall.
        idx_in     = 0;
        idx_out    = 0;
        prev_stall = 1'b0;
        prev_obs   = 20'd0;
        for (int cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (idx_in < 8);
            in_data   = (idx_in < 8) ? d_in[idx_in] : 32'd0;
            #1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_flags, out_data}, prev_obs);
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = {out_flags, out_data};
            fire_in    = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream_%0d", idx_out), {out_flags, out_data}, d_exp[idx_out]);
                idx_out++;
            end
            if (fire_in)
                idx_in++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", idx_out, 8);
        chk("stream_accepted", idx_in, 8);
        #1;
        chk("stream_empty", out_valid, 0);
        tick();

        // Reset asserted mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = d_in[i];
            tick();
        end
        chk("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 16'h0000);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no_replay_%0d", i), out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
